// File: rtl/dmem_bridge.sv
// Bridge between a single-cycle CPU data port and a slow, ack-based data memory.
// A request stalls the CPU until the memory acks, the access times out, or it is rejected as misaligned.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        err_clr,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  tmo_cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        we_r;
    logic        req_r;
    logic        err_mis_r;
    logic        err_tmo_r;

    logic        access_s;
    logic        aligned_s;
    logic        stall_s;
    logic        set_mis_s;
    logic        set_tmo_s;

    // Request decode, stall and error-set conditions
    always_comb begin
        access_s  = cpu_mem_read | cpu_mem_write;
        aligned_s = (cpu_addr[1:0] == 2'b00);
        stall_s   = ((state_r == IDLE) & access_s) | (state_r == BUSY);
        set_mis_s = (state_r == IDLE) & access_s & ~aligned_s;
        set_tmo_s = (state_r == BUSY) & ~mem_ack & (tmo_cnt_r == TMO_LAST);
    end

    // Access FSM with its latched address/data/direction and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            tmo_cnt_r <= 8'd0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            we_r      <= 1'b0;
            req_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s && aligned_s) begin
                        addr_r    <= cpu_addr;
                        wdata_r   <= cpu_wdata;
                        we_r      <= cpu_mem_write;
                        tmo_cnt_r <= 8'd0;
                        req_r     <= 1'b1;
                        state_r   <= BUSY;
                    end else if (access_s) begin
                        rdata_r <= 32'h0000_0000;
                        state_r <= DONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // An ack on the final allowed cycle still completes normally
                    if (mem_ack) begin
                        rdata_r <= we_r ? 32'h0000_0000 : mem_rdata;
                        req_r   <= 1'b0;
                        state_r <= DONE;
                    end else if (set_tmo_s) begin
                        rdata_r <= 32'hDEAD_BEEF;
                        req_r   <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    req_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_mis_r <= 1'b0;
            err_tmo_r <= 1'b0;
        end else begin
            err_mis_r <= set_mis_s ? 1'b1 : (err_clr ? 1'b0 : err_mis_r);
            err_tmo_r <= set_tmo_s ? 1'b1 : (err_clr ? 1'b0 : err_tmo_r);
        end
    end

    assign stall        = stall_s;
    assign mem_req      = req_r;
    assign mem_we       = we_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign cpu_rdata    = rdata_r;
    assign err_misalign = err_mis_r;
    assign err_timeout  = err_tmo_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: two instances (TIMEOUT 16 and 4) share stimulus,
// with a directed vector table, random transactions against a transaction-level model, and hand sequences.
module tb_dmem_bridge;

    localparam int T_A = 16;
    localparam int T_B = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic        cpu_mem_read, cpu_mem_write, mem_ack, err_clr;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] rdata_a, rdata_b, maddr_a, maddr_b, mwdata_a, mwdata_b;
    logic        stall_a, stall_b, req_a, req_b, we_a, we_b;
    logic        mis_a, mis_b, tmo_a, tmo_b;

    logic [31:0] rdata_m, addr_m, wdata_m;
    logic        stall_m, req_m, we_m, mis_m, tmo_m;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rd_a = cpu_mem_read  & ~sel;
    assign wr_a = cpu_mem_write & ~sel;
    assign rd_b = cpu_mem_read  &  sel;
    assign wr_b = cpu_mem_write &  sel;

    dmem_bridge #(.TIMEOUT(T_A)) dut_a (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mem_read(rd_a), .cpu_mem_write(wr_a), .cpu_rdata(rdata_a), .stall(stall_a),
        .mem_req(req_a), .mem_we(we_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_clr(err_clr),
        .err_misalign(mis_a), .err_timeout(tmo_a)
    );

    dmem_bridge #(.TIMEOUT(T_B)) dut_b (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mem_read(rd_b), .cpu_mem_write(wr_b), .cpu_rdata(rdata_b), .stall(stall_b),
        .mem_req(req_b), .mem_we(we_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_clr(err_clr),
        .err_misalign(mis_b), .err_timeout(tmo_b)
    );

    always_comb begin
        stall_m = sel ? stall_b  : stall_a;
        req_m   = sel ? req_b    : req_a;
        we_m    = sel ? we_b     : we_a;
        addr_m  = sel ? maddr_b  : maddr_a;
        wdata_m = sel ? mwdata_b : mwdata_a;
        rdata_m = sel ? rdata_b  : rdata_a;
        mis_m   = sel ? mis_b    : mis_a;
        tmo_m   = sel ? tmo_b    : tmo_a;
    end

    typedef struct {
        logic        sel;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;
        logic [31:0] ack_data;
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_tmo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: outcome depends only on alignment, ack arrival and the timeout window
    function automatic void model(input int t, input logic wr, input logic [31:0] addr,
                                  input int ack_at, input logic [31:0] ack_data,
                                  output int st, output int rq, output logic [31:0] rdat,
                                  output logic mis, output logic tmo);
        if (addr[1:0] != 2'b00) begin
            st = 1; rq = 0; rdat = 32'h0; mis = 1'b1; tmo = 1'b0;
        end else if (ack_at >= 1 && ack_at <= t) begin
            st = ack_at + 1; rq = ack_at; rdat = wr ? 32'h0 : ack_data; mis = 1'b0; tmo = 1'b0;
        end else begin
            st = t + 1; rq = t; rdat = 32'hDEADBEEF; mis = 1'b0; tmo = 1'b1;
        end
    endfunction

    // Drive one CPU access; the memory responder acks on the ack_at-th cycle that mem_req is seen high
    task automatic run_txn(input vec_t v, input logic scramble, input string tag);
        int          busy_n, n_stall, n_req;
        logic        done, bus_ok;
        logic        wr_eff;
        logic [31:0] rdata_done;
        logic        mis, tmo;
        busy_n = 0; n_stall = 0; n_req = 0; done = 1'b0; bus_ok = 1'b1;
        rdata_done = 32'h0; mis = 1'b0; tmo = 1'b0;
        wr_eff = v.wr;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                sel = v.sel; cpu_mem_read = v.rd; cpu_mem_write = v.wr;
                cpu_addr = v.addr; cpu_wdata = v.wdata; err_clr = 1'b1;
            end else begin
                err_clr = 1'b0;
            end
            #1;
            if (req_m) begin
                busy_n++;
                mem_ack   = (busy_n == v.ack_at);
                mem_rdata = (busy_n == v.ack_at) ? v.ack_data : $urandom;
                if (scramble) begin
                    cpu_addr = $urandom; cpu_wdata = $urandom;
                end
            end else begin
                mem_ack   = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            if (req_m) begin
                n_req++;
                if (we_m !== wr_eff || addr_m !== v.addr || wdata_m !== v.wdata) bus_ok = 1'b0;
            end
            if (stall_m) begin
                n_stall++;
            end else begin
                done = 1'b1; rdata_done = rdata_m; mis = mis_m; tmo = tmo_m;
            end
        end
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
        check({tag, " completes"}, 32'(done), 32'd1);
        check({tag, " stall_cycles"}, n_stall, v.exp_stall);
        check({tag, " req_cycles"}, n_req, v.exp_req);
        check({tag, " cpu_rdata"}, rdata_done, v.exp_rdata);
        check({tag, " err_misalign"}, 32'(mis), 32'(v.exp_mis));
        check({tag, " err_timeout"}, 32'(tmo), 32'(v.exp_tmo));
        check({tag, " mem_bus_stable"}, 32'(bus_ok), 32'd1);
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        rst = 1'b1; sel = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; err_clr = 1'b0;

        //            sel   rd    wr    addr          wdata         ack data          st rq rdata         mis   tmo
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        1, 32'hCAFEF00D,  2, 1, 32'hCAFEF00D, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h12345678, 5, 32'hFFFF0000,  6, 5, 32'h0,        1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0,        1, 32'h11112222,  1, 0, 32'h0,        1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 32'h0,         5, 4, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0,        4, 32'h0BADF00D,  5, 4, 32'h0BADF00D, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'hA5A5A5A5, 2, 32'h11111111,  3, 2, 32'h0,        1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0007, 32'h5,        1, 32'h1,         1, 0, 32'h0,        1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        0, 32'h0,        17,16, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h0,        5, 32'h77777777,  5, 4, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h87654321, 1, 32'h33333333,  2, 1, 32'h0,        1'b0, 1'b0};

        // Reset state, both during and after reset
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_during mem_req", 32'({req_a, req_b}), 32'd0);
        check("rst_during mem_we", 32'({we_a, we_b}), 32'd0);
        check("rst_during cpu_rdata", rdata_a | rdata_b, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_after stall", 32'({stall_a, stall_b}), 32'd0);
        check("rst_after errs", 32'({mis_a, tmo_a, mis_b, tmo_b}), 32'd0);
        check("rst_after mem_addr", maddr_a | mwdata_a | maddr_b | mwdata_b, 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Misaligned error stays sticky until err_clr
        run_txn(tbl[2], 1'b0, "sticky");
        @(posedge clk); #1;
        @(negedge clk);
        check("sticky hold err_misalign", 32'(mis_a), 32'd1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("err_clr err_misalign", 32'(mis_a), 32'd0);

        // Random transactions, with cpu inputs scrambled during BUSY and stray acks outside it
        for (int i = 0; i < 40; i++) begin
            int wsel;
            rv.sel = 1'($urandom_range(0, 1));
            wsel   = $urandom_range(0, 2);
            rv.rd  = (wsel != 1);
            rv.wr  = (wsel != 0);
            rv.addr = $urandom;
            if ($urandom_range(0, 3) != 0) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.ack_at = $urandom_range(0, (rv.sel ? T_B : T_A) + 2);
            rv.ack_data = $urandom;
            model(rv.sel ? T_B : T_A, rv.wr, rv.addr, rv.ack_at, rv.ack_data,
                  rv.exp_stall, rv.exp_req, rv.exp_rdata, rv.exp_mis, rv.exp_tmo);
            run_txn(rv, 1'b1, $sformatf("rnd%0d", i));
        end

        // Reset in the second BUSY cycle abandons the access; later stray ack is ignored
        @(posedge clk); #1;
        sel = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 32'h0000_0300; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst busy mem_req", 32'(req_a), 32'd1);
        rst = 1'b1; cpu_mem_read = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst mem_req", 32'(req_a), 32'd0);
        check("midrst stall", 32'(stall_a), 32'd0);
        check("midrst errs", 32'({mis_a, tmo_a}), 32'd0);
        check("midrst cpu_rdata", rdata_a, 32'h0);
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack mem_req", 32'(req_a), 32'd0);
        check("stray_ack stall", 32'(stall_a), 32'd0);
        check("stray_ack cpu_rdata", rdata_a, 32'h0);
        check("stray_ack errs", 32'({mis_a, tmo_a}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
